// File: rtl/instr_mem_loader_if.sv
// Symbolic-instruction handshake between a program source and the instruction memory loader.
interface instr_mem_loader_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  in_kind_i;
    logic [4:0]  in_rs_i;
    logic [4:0]  in_rt_i;
    logic [4:0]  in_rd_i;
    logic [15:0] in_imm_i;
    logic        in_last_i;

    modport master (
        output in_valid_i, in_kind_i, in_rs_i, in_rt_i, in_rd_i, in_imm_i, in_last_i,
        input  in_ready_o
    );

    modport slave (
        input  in_valid_i, in_kind_i, in_rs_i, in_rt_i, in_rd_i, in_imm_i, in_last_i,
        output in_ready_o
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Encodes symbolic MIPS instructions and writes them to consecutive instruction memory words,
// reporting program length, completion and load errors.
module instr_mem_loader #(
    parameter int unsigned INSTR_NUM = 256,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    instr_mem_loader_if.slave   in_if,
    input  logic                clear_i,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [31:0]         mem_wdata_o,
    output logic                done_o,
    output logic [ADDR_W:0]     prog_len_o,
    output logic                err_o,
    output logic [1:0]          err_code_o
);

    typedef enum logic [1:0] {StIdle, StWrite, StDone, StErr} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W:0]     len_q;
    logic                last_q;
    logic [1:0]          err_code_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;

    logic                ready;
    logic                accept;
    logic                kind_illegal;
    logic                beq_oor;
    logic                ptr_full;
    logic [15:0]         beq_off;
    logic [31:0]         enc_word;

    assign accept       = in_if.in_valid_i && ready;
    assign kind_illegal = in_if.in_kind_i > 4'd9;
    assign beq_oor      = (in_if.in_kind_i == 4'd9) && (32'(in_if.in_imm_i) > (INSTR_NUM - 1));
    assign ptr_full     = ptr_q == ADDR_W'(INSTR_NUM - 1);

    // Both operands are below INSTR_NUM, so 16-bit wraparound equals the 17-bit result truncated.
    assign beq_off = 16'(in_if.in_imm_i[ADDR_W-1:0]) - 16'(ptr_q) - 16'd1;

    always_comb begin
        enc_word = 32'd0;
        unique case (in_if.in_kind_i)
            4'd0: enc_word = {6'h00, in_if.in_rs_i, in_if.in_rt_i, in_if.in_rd_i, 5'd0, 6'h20};
            4'd1: enc_word = {6'h00, in_if.in_rs_i, in_if.in_rt_i, in_if.in_rd_i, 5'd0, 6'h22};
            4'd2: enc_word = {6'h00, in_if.in_rs_i, in_if.in_rt_i, in_if.in_rd_i, 5'd0, 6'h24};
            4'd3: enc_word = {6'h00, in_if.in_rs_i, in_if.in_rt_i, in_if.in_rd_i, 5'd0, 6'h25};
            4'd4: enc_word = {6'h00, in_if.in_rs_i, in_if.in_rt_i, in_if.in_rd_i, 5'd0, 6'h2A};
            4'd5: enc_word = {6'h08, in_if.in_rs_i, in_if.in_rt_i, in_if.in_imm_i};
            4'd6: enc_word = {6'h23, in_if.in_rs_i, in_if.in_rt_i, in_if.in_imm_i};
            4'd7: enc_word = {6'h2B, in_if.in_rs_i, in_if.in_rt_i, in_if.in_imm_i};
            4'd8: enc_word = {6'h0A, in_if.in_rs_i, in_if.in_rt_i, in_if.in_imm_i};
            4'd9: enc_word = {6'h04, in_if.in_rs_i, in_if.in_rt_i, beq_off};
            default: enc_word = 32'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (accept) state_d = (kind_illegal || beq_oor) ? StErr : StWrite;
                StWrite: state_d = (last_q || ptr_full) ? StDone : StIdle;
                StDone:  state_d = StDone;
                StErr:   state_d = StErr;
                default: state_d = StIdle;
            endcase
        end
    end

    // Output logic
    always_comb begin
        ready  = state_q == StIdle;
        done_o = state_q == StDone;
        err_o  = err_code_q != 2'd0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_q       <= '0;
            len_q       <= '0;
            last_q      <= 1'b0;
            err_code_q  <= 2'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
        end else if (clear_i) begin
            ptr_q      <= '0;
            len_q      <= '0;
            last_q     <= 1'b0;
            err_code_q <= 2'd0;
            mem_we_q   <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            if (state_q == StIdle && accept) begin
                if (kind_illegal) begin
                    err_code_q <= 2'd1;
                end else if (beq_oor) begin
                    err_code_q <= 2'd3;
                end else begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= ptr_q;
                    mem_wdata_q <= enc_word;
                    last_q      <= in_if.in_last_i;
                end
            end else if (state_q == StWrite) begin
                ptr_q <= ptr_q + 1'b1;
                len_q <= len_q + 1'b1;
                // Memory filled without an explicit end: program was truncated.
                if (!last_q && ptr_full) err_code_q <= 2'd2;
            end
        end
    end

    assign in_if.in_ready_o = ready;
    assign mem_we_o         = mem_we_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_wdata_o      = mem_wdata_q;
    assign prog_len_o       = len_q;
    assign err_code_o       = err_code_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench: stimulus pushes expected memory writes, a negedge monitor pops and compares.
module tb_instr_mem_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic        mem_we_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        done_o;
    logic [8:0]  prog_len_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    instr_mem_loader_if in_if ();

    instr_mem_loader #(.INSTR_NUM(256), .ADDR_W(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_if       (in_if),
        .clear_i     (clear_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .done_o      (done_o),
        .prog_len_o  (prog_len_o),
        .err_o       (err_o),
        .err_code_o  (err_code_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk_i) begin
        if (rst_i === 1'b1 && mem_we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h, want no write",
                         mem_addr_o, mem_wdata_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", {24'd0, mem_addr_o}, {24'd0, e.addr});
                chk("write_data", mem_wdata_o, e.data);
            end
        end
    end

    task automatic send(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic last,
                        input bit push, input logic [7:0] ea, input logic [31:0] ed);
        int w = 0;
        @(negedge clk_i);
        while (in_if.in_ready_o !== 1'b1 && w < 20) begin
            @(negedge clk_i);
            w++;
        end
        if (in_if.in_ready_o !== 1'b1) begin
            n_total++;
            $display("FAIL send_timeout: in_ready_o=%b, want 1", in_if.in_ready_o);
            return;
        end
        in_if.in_kind_i  = kind;
        in_if.in_rs_i    = rs;
        in_if.in_rt_i    = rt;
        in_if.in_rd_i    = rd;
        in_if.in_imm_i   = imm;
        in_if.in_last_i  = last;
        in_if.in_valid_i = 1'b1;
        if (push) exp_q.push_back('{addr: ea, data: ed});
        @(posedge clk_i);
        #1;
        in_if.in_valid_i = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
    endtask

    task automatic after_edge();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i            = 1'b0;
        clear_i          = 1'b0;
        in_if.in_valid_i = 1'b0;
        in_if.in_kind_i  = 4'd0;
        in_if.in_rs_i    = 5'd0;
        in_if.in_rt_i    = 5'd0;
        in_if.in_rd_i    = 5'd0;
        in_if.in_imm_i   = 16'd0;
        in_if.in_last_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_ready", {31'd0, in_if.in_ready_o}, 32'd1);
        chk("rst_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_addr", {24'd0, mem_addr_o}, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_len", {23'd0, prog_len_o}, 32'd0);
        chk("rst_err", {29'd0, err_o, err_code_o}, 32'd0);

        // Single ADD
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0, 1'b1, 8'd0, 32'h0022_1820);
        after_edge();
        chk("add_len", {23'd0, prog_len_o}, 32'd1);
        chk("add_ready", {31'd0, in_if.in_ready_o}, 32'd1);
        chk("add_we_low", {31'd0, mem_we_o}, 32'd0);
        do_clear();

        // ADDI / LW / SW with last
        send(4'd5, 5'd0, 5'd1, 5'd0, 16'd5, 1'b0, 1'b1, 8'd0, 32'h2001_0005);
        send(4'd6, 5'd0, 5'd4, 5'd0, 16'd8, 1'b0, 1'b1, 8'd1, 32'h8C04_0008);
        send(4'd7, 5'd0, 5'd4, 5'd0, 16'd8, 1'b1, 1'b1, 8'd2, 32'hAC04_0008);
        after_edge();
        chk("prog_done", {31'd0, done_o}, 32'd1);
        chk("prog_len", {23'd0, prog_len_o}, 32'd3);
        chk("prog_ready", {31'd0, in_if.in_ready_o}, 32'd0);
        chk("prog_err", {29'd0, err_o, err_code_o}, 32'd0);
        do_clear();

        // SLT, SLT, backward BEQ; then forward BEQ from address 0
        send(4'd4, 5'd1, 5'd2, 5'd5, 16'd0, 1'b0, 1'b1, 8'd0, 32'h0022_282A);
        send(4'd4, 5'd1, 5'd2, 5'd5, 16'd0, 1'b0, 1'b1, 8'd1, 32'h0022_282A);
        send(4'd9, 5'd1, 5'd2, 5'd0, 16'd0, 1'b1, 1'b1, 8'd2, 32'h1022_FFFD);
        after_edge();
        do_clear();
        send(4'd9, 5'd1, 5'd2, 5'd0, 16'd200, 1'b1, 1'b1, 8'd0, 32'h1022_00C7);
        after_edge();
        chk("beq_fwd_done", {31'd0, done_o}, 32'd1);
        do_clear();

        // Error paths
        send(4'd12, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0, 1'b0, 8'd0, 32'd0);
        chk("illegal_err", {29'd0, err_o, err_code_o}, 32'd5);
        chk("illegal_ready", {31'd0, in_if.in_ready_o}, 32'd0);
        chk("illegal_done", {31'd0, done_o}, 32'd0);
        repeat (3) after_edge();
        do_clear();
        send(4'd9, 5'd1, 5'd2, 5'd0, 16'd300, 1'b0, 1'b0, 8'd0, 32'd0);
        chk("beq_oor_err", {29'd0, err_o, err_code_o}, 32'd7);
        do_clear();
        chk("clear_flags", {29'd0, done_o, err_o, in_if.in_ready_o}, 32'd1);
        chk("clear_code", {30'd0, err_code_o}, 32'd0);
        chk("clear_len", {23'd0, prog_len_o}, 32'd0);

        // Fill all 256 words without a last marker
        for (int i = 0; i < 256; i++)
            send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0, 1'b1, 8'(i), 32'h0022_1820);
        after_edge();
        chk("full_done", {31'd0, done_o}, 32'd1);
        chk("full_err", {29'd0, err_o, err_code_o}, 32'd6);
        chk("full_len", {23'd0, prog_len_o}, 32'd256);
        chk("full_ready", {31'd0, in_if.in_ready_o}, 32'd0);
        @(negedge clk_i);
        in_if.in_valid_i = 1'b1;
        repeat (4) @(negedge clk_i);
        in_if.in_valid_i = 1'b0;
        chk("full_len_hold", {23'd0, prog_len_o}, 32'd256);
        do_clear();

        // Asynchronous reset during the write cycle
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0, 1'b0, 8'd0, 32'd0);
        chk("pre_rst_we", {31'd0, mem_we_o}, 32'd1);
        #1;
        rst_i = 1'b0;
        #1;
        chk("mid_rst_we", {31'd0, mem_we_o}, 32'd0);
        chk("mid_rst_wdata", mem_wdata_o, 32'd0);
        chk("mid_rst_addr", {24'd0, mem_addr_o}, 32'd0);
        chk("mid_rst_len", {23'd0, prog_len_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        send(4'd1, 5'd5, 5'd6, 5'd7, 16'd0, 1'b1, 1'b1, 8'd0, 32'h00A6_3822);
        after_edge();
        chk("post_rst_done", {31'd0, done_o}, 32'd1);
        chk("post_rst_len", {23'd0, prog_len_o}, 32'd1);

        repeat (2) @(negedge clk_i);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
